instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage of the MIPS32 datapath; the producer end of the opcode/instruction path into the control unit and decode logic.
- Holds the PC, reads a combinational instruction memory and registers the instruction word with a valid flag.
- Applies taken-branch redirects with a one-slot squash, supports stall, and halts on a reserved HALT opcode.

Parameters:
- ADDR_W, 6, word-address width into instruction memory (depth 2^ADDR_W words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- HALT_OP, 6'b111111, opcode treated as HALT.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC, IR and valid this cycle.
- branch_taken  input  1  decode/execute resolved a taken branch for the instruction currently in IR.
- branch_imm  input  32  sign-extended 16-bit branch immediate, in words.
- imem_addr  output  ADDR_W  word address to instruction memory; equals pc[ADDR_W+1:2], combinational.
- imem_data  input  32  instruction word at imem_addr, same cycle (asynchronous read).
- instr  output  32  registered instruction word (IR).
- opcode  output  6  instr[31:26], driven to the control unit.
- pc_plus4  output  32  registered PC+4 of the instruction in IR.
- valid  output  1  IR holds a real instruction; consumers ignore IR when 0.
- halted  output  1  HALT reached; fetch stopped.

Behaviour:
- Reset (asynchronous, immediate): pc=RESET_PC; instr=0; pc_plus4=0; valid=0; halted=0; state=START. Takes effect mid-operation and discards all in-flight state.
- States: START, RUN, FLUSH, HALT.
- START: one cycle after reset release. IR<=imem_data; pc_plus4<=pc+4; pc<=pc+4; valid<=1; go to RUN. stall is honoured: if stall=1, hold and stay in START.
- RUN, with stall=0 and no branch:
  - IR<=imem_data; pc_plus4<=pc+4; pc<=pc+4; valid<=1.
  - Fetch-to-IR latency is 1 cycle.
- RUN, with valid=1 and branch_taken=1:
  - pc<=pc_plus4+(branch_imm<<2), computed modulo 2^32.
  - valid<=0; the wrong-path word at pc is squashed and IR contents are don't-care.
  - Go to FLUSH.
  - The branch overrides stall in the same cycle.
- branch_taken while valid=0: ignored.
- FLUSH: behaves as a normal RUN fetch from the target (valid<=1 unless stall), then returns to RUN. A branch_taken in FLUSH is ignored because valid=0.
- stall=1 with no valid branch: pc, instr, pc_plus4, valid and state all hold.
- HALT detection:
  - When valid=1 and opcode==HALT_OP at a non-stalled edge, go to HALT. Set halted<=1 and valid<=0; pc holds its current value.
  - HALT is left only by reset. stall and branch_taken are ignored while in HALT.
- PC arithmetic:
  - All 32-bit, wrapping modulo 2^32 (0xFFFF_FFFC+4 = 0).
  - pc[1:0] stays 00 always, because branch targets are word multiples.
  - imem_addr silently truncates upper PC bits, so memory aliases every 2^ADDR_W words.
- opcode is continuously instr[31:26]; its value is don't-care when valid=0.

Test Plan:
- Reset then free-run, imem[0..3]=0x2008_0005, 0x2009_0003, 0x0109_5020, 0xAC0A_0000:
  - valid rises 1 cycle after reset release.
  - instr sequences through those words; pc_plus4 = 4, 8, 12, 16; opcode = 0x08, 0x08, 0x00, 0x2B.
- BEQ at word 4 with branch_taken=1 while valid, branch_imm=0xFFFF_FFFB (-5):
  - Target = 20+(-20) = 0; valid=0 for one cycle.
  - Next instr = imem[0] with pc_plus4=4.
- stall held 3 cycles while instr=imem[2]:
  - instr, pc_plus4 and valid unchanged; imem_addr stays 3.
  - Sequence resumes with imem[3] after stall drops.
- branch_taken and stall asserted together with valid=1, branch_imm=2, pc_plus4=8:
  - Redirect to 16 taken; valid=0 next cycle; imem[4] follows.
- imem[5]=0xFC00_0000 (HALT):
  - halted=1 and valid=0 one cycle after it appears in IR.
  - pc stays frozen for 10 cycles despite branch_taken pulses.
  - reset returns pc to RESET_PC.
- RESET_PC=0xFFFF_FFF8, ADDR_W=6, free-run:
  - pc_plus4 = 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
  - imem_addr wraps 62, 63, 0.
- Assert reset asynchronously mid-cycle during FLUSH: all outputs reach their reset values before the next clock edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, combinational imem read, registered IR
// with valid flag, taken-branch redirect with one-slot squash, stall and HALT.
module instr_fetch_unit #(
   parameter int unsigned ADDR_W   = 6,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [5:0]  HALT_OP  = 6'b111111
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [31:0]       branch_imm,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   output logic [31:0]       instr,
   output logic [5:0]        opcode,
   output logic [31:0]       pc_plus4,
   output logic              valid,
   output logic              halted
);

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 26;

   // Byte distance between consecutive instruction words.
   localparam logic [WORD_W-1:0] WORD_BYTES = 32'd4;

   // Reset PC is forced onto a word boundary so pc[1:0] can never be nonzero.
   localparam logic [WORD_W-1:0] RESET_PC_ALIGNED = {RESET_PC[WORD_W-1:2], 2'b00};

   // FSM encoding.
   localparam logic [1:0] S_START = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   logic [1:0]        state_q,    state_d;
   logic [WORD_W-1:0] pc_q,       pc_d;
   logic [WORD_W-1:0] instr_q,    instr_d;
   logic [WORD_W-1:0] pc_plus4_q, pc_plus4_d;
   logic              valid_q,    valid_d;
   logic              halted_q,   halted_d;

   logic [WORD_W-1:0] seq_pc;
   logic [WORD_W-1:0] branch_target;
   logic              branch_go;
   logic              halt_hit;

   // Sequential and branch-target PC arithmetic, both wrapping modulo 2^32.
   always_comb begin
      seq_pc        = pc_q + WORD_BYTES;
      branch_target = pc_plus4_q + (branch_imm << 2);
   end

   // Redirect and halt qualifiers; both only act on a real instruction in IR.
   always_comb begin
      branch_go = valid_q & branch_taken;
      halt_hit  = valid_q & (instr_q[OPCODE_MSB:OPCODE_LSB] == HALT_OP);
   end

   // Next-state and datapath update; everything holds unless a case overrides.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      halted_d   = halted_q;

      case (state_q)
         // IR is empty here (after reset or a squash): no branch or halt can apply.
         S_START, S_FLUSH: begin
            if (!stall) begin
               instr_d    = imem_data;
               pc_plus4_d = seq_pc;
               pc_d       = seq_pc;
               valid_d    = 1'b1;
               state_d    = S_RUN;
            end
         end

         // A taken branch wins over stall (and over a coincident HALT opcode);
         // the wrong-path word fetched this cycle is dropped by clearing valid.
         S_RUN: begin
            if (branch_go) begin
               pc_d    = branch_target;
               valid_d = 1'b0;
               state_d = S_FLUSH;
            end else if (!stall) begin
               if (halt_hit) begin
                  halted_d = 1'b1;
                  valid_d  = 1'b0;
                  state_d  = S_HALT;
               end else begin
                  instr_d    = imem_data;
                  pc_plus4_d = seq_pc;
                  pc_d       = seq_pc;
                  valid_d    = 1'b1;
               end
            end
         end

         // Terminal until reset; stall and branch_taken are ignored.
         S_HALT: begin
            state_d = S_HALT;
         end

         default: begin
            state_d = S_START;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_START;
         pc_q       <= RESET_PC_ALIGNED;
         instr_q    <= '0;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
      end
   end

   // Memory address drops the byte offset and aliases above ADDR_W word bits.
   assign imem_addr = pc_q[ADDR_W+1:2];

   assign instr    = instr_q;
   assign opcode   = instr_q[OPCODE_MSB:OPCODE_LSB];
   assign pc_plus4 = pc_plus4_q;
   assign valid    = valid_q;
   assign halted   = halted_q;

endmodule
